// File: rtl/text_overlay_pkg.sv
// ---------------------------------------------------------------------------
// text_overlay_pkg
// Shared constants and types for the text overlay engine:
//   - glyph cell geometry (8 pixels wide, 16 lines high)
//   - the code written by a clear (ASCII space)
//   - the cell-store maintenance FSM state enumeration
// No ports; imported by text_overlay_engine and text_cell_ram.
// ---------------------------------------------------------------------------
package text_overlay_pkg;

  localparam int GLYPH_W = 8;
  localparam int GLYPH_H = 16;
  localparam int CODE_W  = 7;

  localparam logic [CODE_W-1:0] SPACE_CODE = 7'h20;

  typedef enum logic {
    CLEAR = 1'b0,
    IDLE  = 1'b1
  } state_e;

  // Address width for a store of n entries, never narrower than one bit.
  function automatic int addr_width(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/ascii_rom.sv
// ---------------------------------------------------------------------------
// ascii_rom
// 8x16 glyph ROM with a registered (1-cycle) read.
//   clk_i   in   clock
//   addr_i  in   {code[6:0], glyph_row[3:0]}
//   data_o  out  8 glyph pixels, bit 7 = leftmost pixel
// Carries letters A, E, H, I and T; every other printable code shows a box
// outline so unsupported characters remain visible. Control codes, space and
// DEL are blank.
// ---------------------------------------------------------------------------
module ascii_rom (
  input  logic        clk_i,
  input  logic [10:0] addr_i,
  output logic [7:0]  data_o
);

  logic [6:0] code;
  logic [3:0] row;
  logic [7:0] glyph;

  always_comb begin
    code  = addr_i[10:4];
    row   = addr_i[3:0];
    glyph = 8'h00;
    case (code)
      7'h41: case (row)            // A
        4'd2:  glyph = 8'h10;
        4'd3:  glyph = 8'h38;
        4'd4:  glyph = 8'h6C;
        4'd5, 4'd6, 4'd8, 4'd9, 4'd10, 4'd11: glyph = 8'hC6;
        4'd7:  glyph = 8'hFE;
        default: glyph = 8'h00;
      endcase
      7'h45: case (row)            // E
        4'd2, 4'd11: glyph = 8'hFE;
        4'd3, 4'd10: glyph = 8'h66;
        4'd4, 4'd9:  glyph = 8'h62;
        4'd5, 4'd7:  glyph = 8'h68;
        4'd6:        glyph = 8'h78;
        4'd8:        glyph = 8'h60;
        default:     glyph = 8'h00;
      endcase
      7'h48: case (row)            // H
        4'd2, 4'd3, 4'd4, 4'd5, 4'd7, 4'd8, 4'd9, 4'd10, 4'd11: glyph = 8'hC6;
        4'd6:    glyph = 8'hFE;
        default: glyph = 8'h00;
      endcase
      7'h49: case (row)            // I
        4'd2, 4'd11: glyph = 8'h3C;
        4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9, 4'd10: glyph = 8'h18;
        default: glyph = 8'h00;
      endcase
      7'h54: case (row)            // T
        4'd2, 4'd3: glyph = 8'h7E;
        4'd4:       glyph = 8'h5A;
        4'd5, 4'd6, 4'd7, 4'd8, 4'd9, 4'd10: glyph = 8'h18;
        4'd11:      glyph = 8'h3C;
        default:    glyph = 8'h00;
      endcase
      default: begin
        if (code > 7'h20 && code < 7'h7F) begin
          if (row == 4'd2 || row == 4'd11)    glyph = 8'hFE;
          else if (row > 4'd2 && row < 4'd11) glyph = 8'h82;
        end
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    data_o <= glyph;
  end

endmodule

// File: rtl/text_cell_ram.sv
// ---------------------------------------------------------------------------
// text_cell_ram
// Character cell store: one synchronous write port, one synchronous read
// port with 1-cycle latency. No reset on the array so it maps to block RAM.
//   clk_i    in   clock
//   we_i     in   write enable
//   waddr_i  in   write address (row*COLS + col)
//   wdata_i  in   character code to store
//   raddr_i  in   read address
//   rdata_o  out  code at raddr_i, one cycle later
// ---------------------------------------------------------------------------
module text_cell_ram
  import text_overlay_pkg::*;
#(
  parameter int DEPTH  = 128,
  parameter int ADDR_W = 7,
  parameter int DATA_W = CODE_W
) (
  input  logic              clk_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
    rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/text_overlay_engine.sv
// ---------------------------------------------------------------------------
// text_overlay_engine
// Renders a COLS x ROWS window of 8x16 characters onto a VGA pixel stream,
// with a write port into the cell store, a clear command and a blinking
// inverse-video cursor.
//   clk_i, reset_ni                  pixel clock, synchronous active-low reset
//   x_i, y_i                         current pixel coordinate
//   video_on_i, hsync_i, vsync_i     timing aligned with x_i/y_i
//   wr_valid_i / wr_ready_o          cell write handshake
//   wr_col_i, wr_row_i, wr_char_i    write target and code
//   wr_err_o                         pulse after an accepted out-of-range write
//   clear_i                          pulse: fill every cell with a space
//   busy_o                           high while a clear runs
//   cursor_en_i, cursor_col_i, cursor_row_i   cursor control
//   rgb_o, hsync_o, vsync_o          video out, 3 cycles after x_i/y_i
// ---------------------------------------------------------------------------
module text_overlay_engine
  import text_overlay_pkg::*;
#(
  parameter int          ORIGIN_X   = 80,
  parameter int          ORIGIN_Y   = 80,
  parameter int          COLS       = 16,
  parameter int          ROWS       = 8,
  parameter logic [11:0] FG         = 12'hFFF,
  parameter logic [11:0] BG         = 12'h008,
  parameter int          BLINK_LOG2 = 5
) (
  input  logic        clk_i,
  input  logic        reset_ni,
  input  logic [9:0]  x_i,
  input  logic [9:0]  y_i,
  input  logic        video_on_i,
  input  logic        hsync_i,
  input  logic        vsync_i,
  input  logic        wr_valid_i,
  output logic        wr_ready_o,
  input  logic [6:0]  wr_col_i,
  input  logic [4:0]  wr_row_i,
  input  logic [6:0]  wr_char_i,
  input  logic        clear_i,
  input  logic        cursor_en_i,
  input  logic [6:0]  cursor_col_i,
  input  logic [4:0]  cursor_row_i,
  output logic        busy_o,
  output logic        wr_err_o,
  output logic [11:0] rgb_o,
  output logic        hsync_o,
  output logic        vsync_o
);

  localparam int CELLS  = COLS * ROWS;
  localparam int ADDR_W = addr_width(CELLS);
  localparam int FC_W   = BLINK_LOG2 + 1;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(CELLS - 1);
  localparam logic [10:0] X_LO = 11'(ORIGIN_X);
  localparam logic [10:0] X_HI = 11'(ORIGIN_X + GLYPH_W * COLS);
  localparam logic [10:0] Y_LO = 11'(ORIGIN_Y);
  localparam logic [10:0] Y_HI = 11'(ORIGIN_Y + GLYPH_H * ROWS);
  localparam logic [12:0] COLS_L = 13'(COLS);
  localparam logic [7:0]  COLS_C = 8'(COLS);
  localparam logic [5:0]  ROWS_C = 6'(ROWS);

  function automatic logic [ADDR_W-1:0] cell_addr(input logic [6:0] col,
                                                   input logic [5:0] row);
    logic [12:0] lin;
    lin = 13'(row) * COLS_L + 13'(col);
    return lin[ADDR_W-1:0];
  endfunction

  // Inverse video is an XOR of the glyph bit with the cursor hit.
  function automatic logic [11:0] pixel_colour(input logic       vld,
                                               input logic       win,
                                               input logic       cur,
                                               input logic [7:0] glyph,
                                               input logic [2:0] xbit);
    logic on;
    on = glyph[~xbit] ^ cur;
    if (!vld)      return 12'h000;
    else if (!win) return BG;
    else           return on ? FG : BG;
  endfunction

  // Control: clear FSM, write port, frame counter
  state_e            state_q, state_d;
  logic [ADDR_W-1:0] clr_addr_q, clr_addr_d;
  logic              wr_err_q;
  logic              vs_prev_q;
  logic [FC_W-1:0]   frame_q;

  logic              wr_in_range, wr_fire;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_waddr;
  logic [CODE_W-1:0] ram_wdata;

  always_ff @(posedge clk_i) begin
    if (!reset_ni) begin
      state_q    <= CLEAR;
      clr_addr_q <= '0;
      wr_err_q   <= 1'b0;
      vs_prev_q  <= 1'b1;
      frame_q    <= '0;
    end else begin
      state_q    <= state_d;
      clr_addr_q <= clr_addr_d;
      wr_err_q   <= wr_fire & ~wr_in_range;
      vs_prev_q  <= vsync_i;
      if (vs_prev_q && !vsync_i) frame_q <= frame_q + FC_W'(1);
    end
  end

  always_comb begin
    state_d    = state_q;
    clr_addr_d = clr_addr_q;
    case (state_q)
      CLEAR: begin
        if (clear_i) begin
          clr_addr_d = '0;
        end else if (clr_addr_q == LAST_ADDR) begin
          state_d    = IDLE;
          clr_addr_d = '0;
        end else begin
          clr_addr_d = clr_addr_q + ADDR_W'(1);
        end
      end
      IDLE: begin
        if (clear_i) begin
          state_d    = CLEAR;
          clr_addr_d = '0;
        end
      end
      default: begin
        state_d    = CLEAR;
        clr_addr_d = '0;
      end
    endcase
  end

  // Reset is folded in so the handshake outputs are defined before the
  // first clock edge of a reset.
  assign busy_o      = ~reset_ni | (state_q == CLEAR);
  assign wr_ready_o  = reset_ni & (state_q == IDLE) & ~clear_i;
  assign wr_err_o    = wr_err_q;

  assign wr_in_range = ({1'b0, wr_col_i} < COLS_C) && ({1'b0, wr_row_i} < ROWS_C);
  assign wr_fire     = wr_valid_i & wr_ready_o;

  always_comb begin
    ram_we    = 1'b0;
    ram_waddr = cell_addr(wr_col_i, {1'b0, wr_row_i});
    ram_wdata = wr_char_i;
    if (state_q == CLEAR) begin
      ram_we    = 1'b1;
      ram_waddr = clr_addr_q;
      ram_wdata = SPACE_CODE;
    end else if (wr_fire && wr_in_range) begin
      ram_we = 1'b1;
    end
  end

  // Stage 0: window decode and cell lookup
  logic [9:0]        dx, dy;
  logic [6:0]        col;
  logic [5:0]        row;
  logic              in_win, cur_hit;
  logic [ADDR_W-1:0] ram_raddr;
  logic [CODE_W-1:0] cell_code;

  assign dx     = x_i - 10'(ORIGIN_X);
  assign dy     = y_i - 10'(ORIGIN_Y);
  assign col    = dx[9:3];
  assign row    = dy[9:4];
  assign in_win = ({1'b0, x_i} >= X_LO) && ({1'b0, x_i} < X_HI) &&
                  ({1'b0, y_i} >= Y_LO) && ({1'b0, y_i} < Y_HI);
  assign cur_hit = cursor_en_i & frame_q[FC_W-1] & in_win &
                   (col == cursor_col_i) & (row == {1'b0, cursor_row_i});
  // Outside the window the lookup result is discarded; park the address.
  assign ram_raddr = in_win ? cell_addr(col, row) : '0;

  text_cell_ram #(
    .DEPTH  (CELLS),
    .ADDR_W (ADDR_W),
    .DATA_W (CODE_W)
  ) u_cells (
    .clk_i   (clk_i),
    .we_i    (ram_we),
    .waddr_i (ram_waddr),
    .wdata_i (ram_wdata),
    .raddr_i (ram_raddr),
    .rdata_o (cell_code)
  );

  logic       vld_p0, hs_p0, vs_p0, win_p0, cur_p0;
  logic [3:0] grow_p0;
  logic [2:0] xbit_p0;

  always_ff @(posedge clk_i) begin
    if (!reset_ni) begin
      vld_p0  <= 1'b0;
      hs_p0   <= 1'b1;
      vs_p0   <= 1'b1;
      win_p0  <= 1'b0;
      cur_p0  <= 1'b0;
      grow_p0 <= '0;
      xbit_p0 <= '0;
    end else begin
      vld_p0  <= video_on_i;
      hs_p0   <= hsync_i;
      vs_p0   <= vsync_i;
      win_p0  <= in_win;
      cur_p0  <= cur_hit;
      grow_p0 <= dy[3:0];
      xbit_p0 <= dx[2:0];
    end
  end

  // Stage 1: glyph ROM read
  logic [7:0] rom_data;

  ascii_rom u_rom (
    .clk_i  (clk_i),
    .addr_i ({cell_code, grow_p0}),
    .data_o (rom_data)
  );

  logic       vld_p1, hs_p1, vs_p1, win_p1, cur_p1;
  logic [2:0] xbit_p1;

  always_ff @(posedge clk_i) begin
    if (!reset_ni) begin
      vld_p1  <= 1'b0;
      hs_p1   <= 1'b1;
      vs_p1   <= 1'b1;
      win_p1  <= 1'b0;
      cur_p1  <= 1'b0;
      xbit_p1 <= '0;
    end else begin
      vld_p1  <= vld_p0;
      hs_p1   <= hs_p0;
      vs_p1   <= vs_p0;
      win_p1  <= win_p0;
      cur_p1  <= cur_p0;
      xbit_p1 <= xbit_p0;
    end
  end

  // Stage 2: bit select and colour mux
  logic [11:0] rgb_d, rgb_p2;
  logic        hs_p2, vs_p2;

  assign rgb_d = pixel_colour(vld_p1, win_p1, cur_p1, rom_data, xbit_p1);

  always_ff @(posedge clk_i) begin
    if (!reset_ni) begin
      rgb_p2 <= 12'h000;
      hs_p2  <= 1'b1;
      vs_p2  <= 1'b1;
    end else begin
      rgb_p2 <= rgb_d;
      hs_p2  <= hs_p1;
      vs_p2  <= vs_p1;
    end
  end

  assign rgb_o   = rgb_p2;
  assign hsync_o = hs_p2;
  assign vsync_o = vs_p2;

endmodule

// File: tb/tb_text_overlay_engine.sv
// ---------------------------------------------------------------------------
// tb_text_overlay_engine
// Directed bench for text_overlay_engine (BLINK_LOG2 = 1, other defaults).
// Keeps a shadow of the cell contents, the cursor settings and the frame
// count, and predicts every pixel from a hand-entered copy of the A and H
// glyphs.
// ---------------------------------------------------------------------------
module tb_text_overlay_engine;

  localparam int          OX  = 80;
  localparam int          OY  = 80;
  localparam int          NC  = 16;
  localparam int          NR  = 8;
  localparam logic [11:0] FGC = 12'hFFF;
  localparam logic [11:0] BGC = 12'h008;

  logic        clk_i = 1'b0;
  logic        reset_ni;
  logic [9:0]  x_i, y_i;
  logic        video_on_i, hsync_i, vsync_i;
  logic        wr_valid_i, wr_ready_o;
  logic [6:0]  wr_col_i;
  logic [4:0]  wr_row_i;
  logic [6:0]  wr_char_i;
  logic        clear_i;
  logic        cursor_en_i;
  logic [6:0]  cursor_col_i;
  logic [4:0]  cursor_row_i;
  logic        busy_o, wr_err_o;
  logic [11:0] rgb_o;
  logic        hsync_o, vsync_o;

  text_overlay_engine #(.BLINK_LOG2(1)) dut (
    .clk_i        (clk_i),
    .reset_ni     (reset_ni),
    .x_i          (x_i),
    .y_i          (y_i),
    .video_on_i   (video_on_i),
    .hsync_i      (hsync_i),
    .vsync_i      (vsync_i),
    .wr_valid_i   (wr_valid_i),
    .wr_ready_o   (wr_ready_o),
    .wr_col_i     (wr_col_i),
    .wr_row_i     (wr_row_i),
    .wr_char_i    (wr_char_i),
    .clear_i      (clear_i),
    .cursor_en_i  (cursor_en_i),
    .cursor_col_i (cursor_col_i),
    .cursor_row_i (cursor_row_i),
    .busy_o       (busy_o),
    .wr_err_o     (wr_err_o),
    .rgb_o        (rgb_o),
    .hsync_o      (hsync_o),
    .vsync_o      (vsync_o)
  );

  always #5 clk_i = ~clk_i;

  int n_chk  = 0;
  int n_pass = 0;

  logic [6:0] mem [0:NC*NR-1];
  logic       cur_en_m = 1'b0;
  int         ccol_m = 0;
  int         crow_m = 0;
  int         fcnt   = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, act, exp);
  endtask

  function automatic logic [7:0] glyph(input logic [6:0] c, input int r);
    logic [7:0] g;
    g = 8'h00;
    if (c == 7'h41) begin
      case (r)
        2: g = 8'h10;
        3: g = 8'h38;
        4: g = 8'h6C;
        5, 6, 8, 9, 10, 11: g = 8'hC6;
        7: g = 8'hFE;
        default: g = 8'h00;
      endcase
    end else if (c == 7'h48) begin
      if (r == 6) g = 8'hFE;
      else if (r >= 2 && r <= 11) g = 8'hC6;
    end
    return g;
  endfunction

  function automatic logic [11:0] exp_pix(input int xx, input int yy, input logic vid);
    int dx, dy, col, row;
    logic [7:0] g;
    logic b, cur;
    dx = xx - OX;
    dy = yy - OY;
    if (!vid) return 12'h000;
    if (dx < 0 || dx >= 8*NC || dy < 0 || dy >= 16*NR) return BGC;
    col = dx / 8;
    row = dy / 16;
    g   = glyph(mem[row*NC + col], dy % 16);
    b   = g[7 - (dx % 8)];
    cur = cur_en_m && (fcnt >= 2) && (col == ccol_m) && (row == crow_m);
    return (b ^ cur) ? FGC : BGC;
  endfunction

  task automatic set_all_space();
    for (int i = 0; i < NC*NR; i++) mem[i] = 7'h20;
  endtask

  // Streams n pixels of line yy starting at x0, one per clock; the pixel
  // driven in iteration i appears on rgb_o after the edge of iteration i+2.
  task automatic scan(input int yy, input int x0, input int n);
    logic [11:0] er [0:255];
    logic        eh [0:255];
    for (int i = 0; i < n + 2; i++) begin
      if (i < n) begin
        x_i        = 10'(x0 + i);
        y_i        = 10'(yy);
        video_on_i = ((i % 7) != 3);
        hsync_i    = ((i % 5) != 0);
        er[i]      = exp_pix(x0 + i, yy, video_on_i);
        eh[i]      = hsync_i;
      end else begin
        video_on_i = 1'b0;
        hsync_i    = 1'b1;
      end
      @(posedge clk_i); #1;
      if (i >= 2) begin
        chk($sformatf("rgb(%0d,%0d)", x0 + i - 2, yy), rgb_o, er[i-2]);
        chk($sformatf("hsync(%0d,%0d)", x0 + i - 2, yy), hsync_o, eh[i-2]);
      end
    end
  endtask

  task automatic scan_all();
    for (int r = 0; r < NR; r++) scan(OY + 16*r + 6, OX - 4, 8*NC + 8);
  endtask

  task automatic count_busy(input string tag);
    int n;
    n = 0;
    while (busy_o && n < 1000) begin
      @(posedge clk_i); #1;
      n++;
    end
    chk(tag, n, 128);
    chk({tag, "_rdy"}, wr_ready_o, 1);
    set_all_space();
  endtask

  task automatic wr(input int col, input int row, input logic [6:0] ch, input logic exp_err);
    wr_col_i   = 7'(col);
    wr_row_i   = 5'(row);
    wr_char_i  = ch;
    wr_valid_i = 1'b1;
    #1;
    chk($sformatf("wr_ready(%0d,%0d)", col, row), wr_ready_o, 1);
    @(posedge clk_i); #1;
    wr_valid_i = 1'b0;
    chk($sformatf("wr_err(%0d,%0d)", col, row), wr_err_o, exp_err);
    if (!exp_err) mem[row*NC + col] = ch;
    @(posedge clk_i); #1;
    chk($sformatf("wr_err_end(%0d,%0d)", col, row), wr_err_o, 0);
  endtask

  task automatic frame_tick();
    vsync_i = 1'b0;
    @(posedge clk_i); #1;
    vsync_i = 1'b1;
    @(posedge clk_i); #1;
    fcnt = (fcnt + 1) % 4;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_ni = 1'b0;
    x_i = '0; y_i = '0;
    video_on_i = 1'b0; hsync_i = 1'b1; vsync_i = 1'b1;
    wr_valid_i = 1'b0; wr_col_i = '0; wr_row_i = '0; wr_char_i = '0;
    clear_i = 1'b0;
    cursor_en_i = 1'b0; cursor_col_i = '0; cursor_row_i = '0;
    set_all_space();

    // Reset values
    repeat (3) @(posedge clk_i);
    #1;
    chk("rst_rgb", rgb_o, 12'h000);
    chk("rst_hsync", hsync_o, 1);
    chk("rst_vsync", vsync_o, 1);
    chk("rst_busy", busy_o, 1);
    chk("rst_wr_ready", wr_ready_o, 0);
    chk("rst_wr_err", wr_err_o, 0);

    // Initial clear after reset release
    @(posedge clk_i); #1;
    reset_ni = 1'b1;
    #1;
    chk("rel_busy", busy_o, 1);
    count_busy("init_clear_cycles");
    scan_all();

    // 'A' at (0,0): full glyph plus border pixels
    wr(0, 0, 7'h41, 1'b0);
    for (int yy = OY - 1; yy <= OY + 16; yy++) scan(yy, OX - 2, 12);

    // Out-of-range writes leave storage untouched
    wr(16, 0, 7'h48, 1'b1);
    wr(0, 8, 7'h48, 1'b1);
    wr(127, 31, 7'h48, 1'b1);
    scan(OY + 6, OX - 4, 8*NC + 8);
    scan(OY + 22, OX - 4, 8*NC + 8);

    // More cells, including the last column and row
    wr(5, 1, 7'h48, 1'b0);
    wr(15, 7, 7'h48, 1'b0);
    wr(0, 7, 7'h48, 1'b0);
    scan(OY + 22, OX - 4, 8*NC + 8);
    scan(OY + 118, OX - 4, 8*NC + 8);

    // Clear pulse with a write pending: the write is refused
    wr_col_i = 7'd2; wr_row_i = 5'd2; wr_char_i = 7'h48;
    wr_valid_i = 1'b1;
    clear_i = 1'b1;
    #1;
    chk("clr_wr_ready", wr_ready_o, 0);
    @(posedge clk_i); #1;
    clear_i = 1'b0;
    wr_valid_i = 1'b0;
    chk("clr_busy", busy_o, 1);
    chk("clr_wr_err", wr_err_o, 0);
    count_busy("clear_cycles");
    scan_all();

    // Clear pulse during a clear restarts from address 0
    clear_i = 1'b1;
    @(posedge clk_i); #1;
    clear_i = 1'b0;
    repeat (60) @(posedge clk_i);
    #1;
    chk("mid_clear_busy", busy_o, 1);
    chk("mid_clear_wr_ready", wr_ready_o, 0);
    clear_i = 1'b1;
    @(posedge clk_i); #1;
    clear_i = 1'b0;
    count_busy("restart_cycles");

    // Cursor blink on cell (3,2): inverted on frames 2-3 only
    wr(3, 2, 7'h41, 1'b0);
    cursor_en_i = 1'b1; cursor_col_i = 7'd3; cursor_row_i = 5'd2;
    cur_en_m = 1'b1; ccol_m = 3; crow_m = 2;
    for (int f = 0; f < 6; f++) begin
      scan(OY + 32 + 5, OX + 20, 16);
      frame_tick();
    end

    // Reset in the middle of a clear, with video activity in flight
    clear_i = 1'b1;
    @(posedge clk_i); #1;
    clear_i = 1'b0;
    repeat (47) @(posedge clk_i);
    #1;
    x_i = 10'(OX + 4); y_i = 10'(OY + 6);
    video_on_i = 1'b1; hsync_i = 1'b0; vsync_i = 1'b0;
    repeat (3) @(posedge clk_i);
    #1;
    chk("pre_rst_hsync", hsync_o, 0);
    reset_ni = 1'b0;
    @(posedge clk_i); #1;
    chk("mid_rst_rgb", rgb_o, 12'h000);
    chk("mid_rst_hsync", hsync_o, 1);
    chk("mid_rst_vsync", vsync_o, 1);
    chk("mid_rst_busy", busy_o, 1);
    chk("mid_rst_wr_ready", wr_ready_o, 0);
    chk("mid_rst_wr_err", wr_err_o, 0);
    @(posedge clk_i); #1;
    video_on_i = 1'b0; hsync_i = 1'b1; vsync_i = 1'b1;
    reset_ni = 1'b1;
    fcnt = 0;
    count_busy("rst_restart_cycles");
    // Frame counter restarted at 0, so the cursor cell is drawn normally
    scan(OY + 32 + 5, OX + 20, 16);
    scan_all();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/text_overlay_engine.md
TEXT_OVERLAY_ENGINE -- requirements
Module: text_overlay_engine

Interface
REQ-001 Parameter ORIGIN_X, default 80, pixel x of the top-left corner of the text window.
REQ-002 Parameter ORIGIN_Y, default 80, pixel y of the top-left corner of the text window.
REQ-003 Parameter COLS, default 16, characters per text row (1..80).
REQ-004 Parameter ROWS, default 8, text rows (1..30).
REQ-005 Parameter FG, default 12'hFFF, text colour; BG, default 12'h008, background colour.
REQ-006 Parameter BLINK_LOG2, default 5, cursor toggles every 2^BLINK_LOG2 frames.
REQ-007 clk  in  1  pixel clock; the only clock.
REQ-008 reset  in  1  synchronous, active-low reset.
REQ-009 x, y  in  10 each  current pixel coordinate from vga_sync.
REQ-010 video_on, hsync_in, vsync_in  in  1 each  timing from vga_sync, aligned with x/y.
REQ-011 wr_valid  in  1  character write request; wr_ready  out  1  write accepted when both are high.
REQ-012 wr_col  in  7  target column; wr_row  in  5  target row; wr_char  in  7  ASCII code.
REQ-013 clear  in  1  single-cycle pulse requesting a fill of every cell with 7'h20.
REQ-014 cursor_en  in  1; cursor_col  in  7; cursor_row  in  5  blinking inverse-video cursor.
REQ-015 busy  out  1  high while a clear is in progress.
REQ-016 wr_err  out  1  one-cycle pulse when an out-of-range write is accepted.
REQ-017 rgb  out  12; hsync, vsync  out  1 each  pipelined video outputs.

Function
REQ-018 Cell storage SHALL hold COLS*ROWS 7-bit codes; address = row*COLS + col.
REQ-019 FSM states SHALL be CLEAR and IDLE; reset SHALL enter CLEAR with clear address 0.
REQ-020 CLEAR SHALL write 7'h20 to one cell per cycle, addresses 0..COLS*ROWS-1, then enter IDLE on the following cycle.
REQ-021 A clear pulse in IDLE SHALL enter CLEAR on the next cycle; a clear pulse in CLEAR SHALL restart from address 0.
REQ-022 busy SHALL equal (state == CLEAR); wr_ready SHALL equal (state == IDLE) and (clear == 0).
REQ-023 A write is accepted when wr_valid and wr_ready are both high; the cell updates on that edge; one write per cycle, no backpressure other than wr_ready.
REQ-024 An accepted write with wr_col >= COLS or wr_row >= ROWS SHALL leave storage unchanged and pulse wr_err on the next cycle.
REQ-025 Pixel path SHALL be 3 stages: cell lookup; glyph ROM read, address {code, y[3:0]} via ascii_rom; bit select rom_data[~x[2:0]] plus colour mux.
REQ-026 hsync, vsync and video_on SHALL be delayed by exactly 3 cycles so rgb aligns with them.
REQ-027 The window is ORIGIN_X <= x < ORIGIN_X+8*COLS and ORIGIN_Y <= y < ORIGIN_Y+16*ROWS; cell col = (x-ORIGIN_X)>>3, cell row = (y-ORIGIN_Y)>>4, glyph row = (y-ORIGIN_Y)[3:0].
REQ-028 rgb: delayed video_on low -> 12'h000; outside window -> BG; inside -> FG if glyph bit set, else BG.
REQ-029 Frame counter SHALL increment on each falling edge of vsync_in and wrap at 2^(BLINK_LOG2+1).
REQ-030 When cursor_en is set, the frame counter MSB is 1 and the pixel lies in cell (cursor_row, cursor_col), FG and BG SHALL swap.
REQ-031 A write to the cell being scanned SHALL take effect no later than the next frame; tearing within a frame is allowed.

Reset
REQ-032 While reset is low: rgb = 12'h000, hsync = vsync = 1, busy = 1, wr_ready = 0, wr_err = 0, frame counter = 0, all pipeline registers cleared.
REQ-033 Reset asserted mid-clear or mid-frame SHALL restart the clear from address 0; cell contents are guaranteed only after busy falls.

Structure
REQ-034 Package text_overlay_pkg SHALL hold the glyph size constants (8x16), the space code 7'h20, and the FSM state enumeration.
REQ-035 Cell storage SHALL be a separate sub-module text_cell_ram: one synchronous write port, one synchronous read port, 1-cycle read latency, inferable as block RAM.
REQ-036 ascii_rom SHALL be instantiated unchanged.

Verification
REQ-037 Release reset -> busy stays high for exactly COLS*ROWS=128 cycles, then wr_ready rises; every cell reads 7'h20.
REQ-038 Write 'A' (7'h41) to col 0, row 0, then scan one frame -> rgb at (80..87, 80..95) matches the ascii_rom 'A' glyph in FG/BG, delayed 3 cycles from x/y.
REQ-039 Write col 16, row 0 (COLS=16) -> wr_err pulses once; no cell changes; rgb unchanged.
REQ-040 Pulse clear while wr_valid is held high -> wr_ready low on that cycle, the write is not taken, busy high for 128 cycles.
REQ-041 cursor_en=1 at (3,2) with BLINK_LOG2=1 -> cell (3,2) colours invert on frames 2-3 and are normal on frames 0-1 and 4-5.
REQ-042 Assert reset at clear address 50 -> outputs take reset values; the clear restarts at 0 and completes in 128 cycles.
